// File: rtl/cello_lut_engine.sv
// Reprogrammable N-input truth-table engine: serial table load, valid/ready
// evaluation stream and a full-table sweep mode for characterisation.
module cello_lut_engine #(
  parameter int                      N_INPUTS      = 3,
  parameter logic [2**N_INPUTS-1:0]  DEFAULT_TABLE = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic                cfg_bit,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_INPUTS-1:0] in_bits,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_bit,
  output logic [N_INPUTS-1:0] out_index,
  input  logic                sweep_start,
  output logic                busy,
  output logic                sweep_done
);

  localparam int TBL_W = 2**N_INPUTS;
  localparam int CNT_W = N_INPUTS + 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TBL_W - 1);
  localparam logic [N_INPUTS-1:0] IDX_LAST = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  // Hex-name order: index i lives at bit TBL_W-1-i, which is ~i within N bits.
  function automatic logic lut_lookup(input logic [TBL_W-1:0]    tbl,
                                      input logic [N_INPUTS-1:0] idx);
    logic [N_INPUTS-1:0] pos;
    pos = ~idx;
    return tbl[pos];
  endfunction

  state_t              state_q,     state_d;
  logic [TBL_W-1:0]    table_q,     table_d;
  logic [TBL_W-1:0]    shadow_q,    shadow_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic                pending_q,   pending_d;
  logic [N_INPUTS-1:0] k_q,         k_d;
  logic                issued_q,    issued_d;
  logic                out_valid_q, out_valid_d;
  logic                out_bit_q,   out_bit_d;
  logic [N_INPUTS-1:0] out_index_q, out_index_d;
  logic                done_q,      done_d;

  logic slot_free;
  logic in_accept;
  logic cfg_accept;
  logic commit;

  always_comb begin
    slot_free  = !out_valid_q || out_ready;
    in_accept  = (state_q == IDLE) && slot_free && in_valid;
    cfg_accept = !pending_q && cfg_valid;
    commit     = (state_q == IDLE) && pending_q;

    state_d     = state_q;
    table_d     = table_q;
    shadow_d    = shadow_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    k_d         = k_q;
    issued_d    = issued_q;
    out_valid_d = out_valid_q;
    out_bit_d   = out_bit_q;
    out_index_d = out_index_q;
    done_d      = 1'b0;

    // Serial configuration into the shadow register; commit only while idle
    if (cfg_accept) begin
      shadow_d = {shadow_q[TBL_W-2:0], cfg_bit};
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        pending_d = 1'b1;
      end
    end
    if (commit) begin
      table_d   = shadow_q;
      cnt_d     = '0;
      pending_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (in_accept) begin
          out_valid_d = 1'b1;
          out_bit_d   = lut_lookup(table_q, in_bits);
          out_index_d = in_bits;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
        if (sweep_start) begin
          state_d  = SWEEP;
          k_d      = '0;
          issued_d = 1'b0;
        end
      end
      SWEEP: begin
        // issued_q marks that the last index is sitting in the output register
        if (!issued_q && slot_free) begin
          out_valid_d = 1'b1;
          out_bit_d   = lut_lookup(table_q, k_q);
          out_index_d = k_q;
          k_d         = k_q + 1'b1;
          if (k_q == IDX_LAST) begin
            issued_d = 1'b1;
          end
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (issued_q) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            issued_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      table_q     <= DEFAULT_TABLE;
      shadow_q    <= '0;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      k_q         <= '0;
      issued_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_index_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      table_q     <= table_d;
      shadow_q    <= shadow_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      k_q         <= k_d;
      issued_q    <= issued_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_index_q <= out_index_d;
      done_q      <= done_d;
    end
  end

  assign cfg_ready  = !pending_q;
  assign in_ready   = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign out_valid  = out_valid_q;
  assign out_bit    = out_bit_q;
  assign out_index  = out_index_q;
  assign busy       = (state_q == SWEEP);
  assign sweep_done = done_q;

endmodule

// File: tb/tb_cello_lut_engine.sv
// Bench for cello_lut_engine: directed vector tables, corner sequences and a
// randomized run against a queue-based transaction model.
module tb_cello_lut_engine;

  localparam int TW = 8;

  logic       clk = 1'b0;
  logic       rst, cfg_valid, cfg_bit, in_valid, out_ready, sweep_start;
  logic [2:0] in_bits;
  logic       cfg_ready, in_ready, out_valid, out_bit, busy, sweep_done;
  logic [2:0] out_index;

  logic       sweep_start4, out_ready4;
  logic       cfg_ready4, in_ready4, out_valid4, out_bit4, busy4, sweep_done4;
  logic [3:0] out_index4;

  always #5 clk = ~clk;

  cello_lut_engine #(.N_INPUTS(3), .DEFAULT_TABLE(8'h08)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_bit(cfg_bit),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit), .out_index(out_index),
    .sweep_start(sweep_start), .busy(busy), .sweep_done(sweep_done)
  );

  cello_lut_engine #(.N_INPUTS(4), .DEFAULT_TABLE(16'h8000)) dut4 (
    .clk(clk), .rst(rst),
    .cfg_valid(1'b0), .cfg_ready(cfg_ready4), .cfg_bit(1'b0),
    .in_valid(1'b0), .in_ready(in_ready4), .in_bits(4'd0),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_bit(out_bit4), .out_index(out_index4),
    .sweep_start(sweep_start4), .busy(busy4), .sweep_done(sweep_done4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [2:0] idx;
    logic       exp08;
    logic       exp96;
  } vec_t;
  vec_t vecs [8];

  // ---------------- reference model ----------------
  logic [7:0] m_tbl, m_shadow;
  int         m_cnt;
  bit         m_pend, m_busy, m_done, m_ov, m_obit, m_last;
  logic [2:0] m_oidx;
  int         sq_idx [$];
  bit         sq_bit [$];

  function automatic logic ref_bit(input logic [7:0] tbl, input int idx);
    return tbl[TW - 1 - idx];
  endfunction

  always @(posedge clk) begin
    bit slot, old_busy, old_pend;
    if (rst) begin
      m_tbl = 8'h08; m_shadow = 8'h00; m_cnt = 0; m_pend = 0; m_busy = 0;
      m_done = 0; m_ov = 0; m_obit = 0; m_oidx = 3'd0; m_last = 0;
      sq_idx.delete(); sq_bit.delete();
    end else begin
      slot = !m_ov || out_ready;
      old_busy = m_busy;
      old_pend = m_pend;
      m_done = 0;
      if (!old_busy && slot && in_valid) begin
        m_ov = 1; m_oidx = in_bits; m_obit = ref_bit(m_tbl, int'(in_bits));
      end else if (old_busy && slot && sq_idx.size() > 0) begin
        m_oidx = 3'(sq_idx.pop_front());
        m_obit = sq_bit.pop_front();
        m_ov = 1;
        m_last = (sq_idx.size() == 0);
      end else if (m_ov && out_ready) begin
        m_ov = 0;
        if (old_busy && m_last) begin
          m_busy = 0; m_done = 1; m_last = 0;
        end
      end
      if (old_pend && !old_busy) begin
        m_tbl = m_shadow; m_cnt = 0; m_pend = 0;
      end
      if (!old_busy && sweep_start) begin
        m_busy = 1; m_last = 0;
        for (int i = 0; i < TW; i++) begin
          sq_idx.push_back(i);
          sq_bit.push_back(ref_bit(m_tbl, i));
        end
      end
      if (!old_pend && cfg_valid) begin
        m_shadow = {m_shadow[6:0], cfg_bit};
        m_cnt++;
        if (m_cnt == TW) m_pend = 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    logic [8:0] e, a;
    e = {m_ov, m_ov & m_obit, m_ov ? m_oidx : 3'd0,
         !m_busy && (!m_ov || out_ready), !m_pend, m_busy, m_done};
    a = {out_valid, m_ov & out_bit, m_ov ? out_index : 3'd0,
         in_ready, cfg_ready, busy, sweep_done};
    chk("model_cycle", 32'(a), 32'(e));
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    check_cycle();
  endtask

  // Sweep with out_ready held high; optionally feed a config word alongside.
  task automatic sweep_check(input bit col96, input logic [7:0] word, input bit feed);
    logic eb;
    out_ready = 1; sweep_start = 1;
    cyc();
    sweep_start = 0;
    chk("sweep_busy", 32'(busy), 32'd1);
    for (int i = 0; i < TW; i++) begin
      if (feed) begin
        cfg_valid = 1; cfg_bit = word[TW - 1 - i];
      end
      cyc();
      eb = col96 ? vecs[i].exp96 : vecs[i].exp08;
      chk("sweep_entry", 32'({out_valid, out_index, out_bit}), 32'({1'b1, vecs[i].idx, eb}));
    end
    cfg_valid = 0;
    cyc();
    chk("sweep_done", 32'({sweep_done, busy, out_valid}), 32'b100);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ld;
    int seen_idx [$];
    bit seen_bit [$];
    bit done_seen;
    logic [4:0] held;
    bit hit;

    vecs[0] = '{idx: 3'd0, exp08: 1'b0, exp96: 1'b1};
    vecs[1] = '{idx: 3'd1, exp08: 1'b0, exp96: 1'b0};
    vecs[2] = '{idx: 3'd2, exp08: 1'b0, exp96: 1'b0};
    vecs[3] = '{idx: 3'd3, exp08: 1'b0, exp96: 1'b1};
    vecs[4] = '{idx: 3'd4, exp08: 1'b1, exp96: 1'b0};
    vecs[5] = '{idx: 3'd5, exp08: 1'b0, exp96: 1'b1};
    vecs[6] = '{idx: 3'd6, exp08: 1'b0, exp96: 1'b1};
    vecs[7] = '{idx: 3'd7, exp08: 1'b0, exp96: 1'b0};

    rst = 1; cfg_valid = 0; cfg_bit = 0; in_valid = 0; in_bits = 0;
    out_ready = 0; sweep_start = 0; sweep_start4 = 0; out_ready4 = 0;
    cyc(); cyc();
    rst = 0;
    chk("reset_state", 32'({out_valid, out_bit, out_index, busy, sweep_done, cfg_ready, in_ready}),
        32'b0_0_000_0_0_1_1);

    // streamed evaluation of the default 8'h08 table
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < TW; i++) begin
      in_bits = vecs[i].idx;
      cyc();
      chk("eval08", 32'({out_valid, out_index, out_bit}), 32'({1'b1, vecs[i].idx, vecs[i].exp08}));
    end
    in_valid = 0;
    cyc();
    chk("eval_drain", 32'(out_valid), 32'd0);

    // serial load of 8'h96, MSB first
    ld = 8'h96;
    for (int i = TW - 1; i >= 0; i--) begin
      cfg_valid = 1; cfg_bit = ld[i];
      cyc();
      chk("cfg_ready_load", 32'(cfg_ready), (i == 0) ? 32'd0 : 32'd1);
    end
    cfg_valid = 0;
    cyc();
    chk("cfg_ready_after_commit", 32'(cfg_ready), 32'd1);
    sweep_check(1'b1, 8'h00, 1'b0);

    // backpressure mid-sweep
    out_ready = 1; sweep_start = 1;
    cyc();
    sweep_start = 0;
    done_seen = 0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      out_ready = !(c >= 3 && c < 8);
      if (out_valid && out_ready) begin
        seen_idx.push_back(int'(out_index));
        seen_bit.push_back(out_bit);
      end
      held = {out_valid, out_index, out_bit};
      cyc();
      if (c >= 3 && c < 8) begin
        chk("bp_hold", 32'({out_valid, out_index, out_bit}), 32'(held));
        chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      if (sweep_done) done_seen = 1;
    end
    chk("bp_done", 32'(done_seen), 32'd1);
    chk("bp_count", 32'(seen_idx.size()), 32'd8);
    for (int i = 0; i < TW && i < seen_idx.size(); i++) begin
      chk("bp_order", 32'({seen_idx[i], seen_bit[i]}), 32'({i, vecs[i].exp96}));
    end

    // load 8'h3C while sweeping 8'h08; commit waits for IDLE
    rst = 1; cyc(); rst = 0;
    sweep_check(1'b0, 8'h3C, 1'b1);
    chk("cfg_deferred", 32'(cfg_ready), 32'd0);
    cyc();
    chk("cfg_commit_idle", 32'(cfg_ready), 32'd1);
    in_valid = 1; in_bits = 3'd3;
    cyc();
    chk("eval_new_tbl3", 32'({out_valid, out_bit}), 32'b11);
    in_bits = 3'd0;
    cyc();
    chk("eval_new_tbl0", 32'({out_valid, out_bit}), 32'b10);
    in_valid = 0;
    cyc();

    // reset during a sweep with a partial config load in flight
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1; cfg_bit = 1;
      cyc();
    end
    cfg_valid = 0; sweep_start = 1;
    cyc();
    sweep_start = 0;
    hit = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid && out_index == 3'd3) begin hit = 1; break; end
      cyc();
    end
    chk("rst_wait_idx3", 32'(hit), 32'd1);
    rst = 1;
    cyc();
    rst = 0;
    chk("rst_mid_sweep", 32'({out_valid, busy, cfg_ready, sweep_done}), 32'b0010);
    in_valid = 1; in_bits = 3'd3;
    cyc();
    chk("rst_default_tbl3", 32'({out_valid, out_bit}), 32'b10);
    in_bits = 3'd4;
    cyc();
    chk("rst_default_tbl4", 32'({out_valid, out_bit}), 32'b11);
    in_valid = 0;
    for (int i = 0; i < TW; i++) begin
      cfg_valid = 1; cfg_bit = 1'(i);
      cyc();
      chk("partial_discard", 32'(cfg_ready), (i == TW - 1) ? 32'd0 : 32'd1);
    end
    cfg_valid = 0;
    cyc();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      in_valid    = 1'($urandom_range(0, 1));
      in_bits     = 3'($urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
      cfg_valid   = ($urandom_range(0, 2) == 0);
      cfg_bit     = 1'($urandom);
      sweep_start = ($urandom_range(0, 15) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      cyc();
    end
    in_valid = 0; cfg_valid = 0; sweep_start = 0; out_ready = 1; rst = 1;
    cyc();
    rst = 0;
    cyc();

    // N_INPUTS=4, table 16'h8000
    out_ready4 = 1; sweep_start4 = 1;
    cyc();
    sweep_start4 = 0;
    chk("n4_busy", 32'(busy4), 32'd1);
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk("n4_entry", 32'({out_valid4, out_index4, out_bit4}),
          32'({1'b1, 4'(i), (i == 0) ? 1'b1 : 1'b0}));
    end
    cyc();
    chk("n4_done", 32'({sweep_done4, busy4, out_valid4, cfg_ready4, in_ready4}), 32'b10011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cello_lut_engine.md
# cello_lut_engine

Parametrised, reprogrammable successor to the fixed 3-input truth-table gates. It holds an N-input Boolean truth table that can be reloaded at run time through a serial configuration port. It evaluates input vectors through a registered valid/ready stream. A sweep mode streams the complete truth table out, index by index, for characterisation against the genetic-circuit model.

## Interface
- N_INPUTS, 3, number of logic inputs; table holds 2^N_INPUTS bits.
- DEFAULT_TABLE, 0, 2^N_INPUTS-bit truth table loaded at reset, in hex-name order (see Operation).

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- cfg_valid  input  1  a configuration bit is offered.
- cfg_ready  output  1  configuration bit can be accepted.
- cfg_bit  input  1  serial truth-table bit, hex-name MSB first.
- in_valid  input  1  input vector offered.
- in_ready  output  1  input vector can be accepted.
- in_bits  input  N_INPUTS  {in1,…,inN}; in1 is the MSB.
- out_valid  output  1  result held in output register.
- out_ready  input  1  consumer takes result.
- out_bit  output  1  truth-table value.
- out_index  output  N_INPUTS  input vector / sweep index of out_bit.
- sweep_start  input  1  request a full-table sweep (single-cycle pulse).
- busy  output  1  sweep in progress.
- sweep_done  output  1  one-cycle pulse when the last sweep entry is accepted.

## Operation
- Table convention: the hex name is read MSB first as the outputs for index 0, 1, …, 2^N-1.
  - The output for index i is TABLE[2^N-1-i].
  - Example: 0x08 gives 1 only for in_bits=3'b100.
- Configuration:
  - Each cfg_valid&cfg_ready handshake shifts cfg_bit into the shadow register and increments a bit counter.
  - After 2^N bits, pending_commit is set and cfg_ready drops.
  - Commit copies shadow to the active table on the first edge where state=IDLE and pending_commit=1.
  - Commit clears the counter and pending_commit; cfg_ready rises the cycle after commit.
  - The active table never changes during a sweep; a commit is deferred until the sweep ends.
- Evaluation (IDLE only): in_ready = (state==IDLE) & (!out_valid | out_ready).
  - On accept, out_bit is set from the active table, out_index = in_bits, and out_valid = 1.
- Output register: out_valid holds with stable out_bit/out_index until out_ready.
  - If out_valid&out_ready and there is no new load, out_valid clears.
- State machine:
  - IDLE → SWEEP on sweep_start when state=IDLE; sweep counter k=0. sweep_start while in SWEEP is ignored.
  - SWEEP: whenever the slot is free (!out_valid | out_ready), load index k and table value, then k++.
  - After index 2^N-1 is accepted by the consumer: sweep_done=1 for one cycle, SWEEP → IDLE.
  - in_ready=0 throughout SWEEP.
- Simultaneous events:
  - A commit and an in_valid accept in the same cycle: the evaluation uses the old table.
  - A commit and sweep_start in the same cycle: the sweep uses the new table.
  - An in_valid accept and sweep_start in the same cycle: the input is evaluated first; the sweep entries follow.
- Reset: any state goes to IDLE.
  - Table = DEFAULT_TABLE; shadow, counter and pending_commit cleared.
  - Outputs: out_valid=0, out_bit=0, out_index=0, busy=0, sweep_done=0, cfg_ready=1.
  - in_ready=1 from the first cycle after reset.
  - A reset mid-sweep or mid-load discards all partial progress.

## Timing
- Evaluation latency: in accept edge → out_valid on the next cycle (1 cycle).
- Throughput: 1 result per cycle with out_ready held high.
- Sweep:
  - sweep_start edge → index 0 valid 1 cycle later.
  - 2^N consecutive cycles with out_ready=1.
  - sweep_done is asserted in the cycle after the last accept; busy falls at that same edge.
- Config load: 2^N handshakes, commit at the next IDLE edge, cfg_ready high again one cycle later.
- No combinational path from in_valid/cfg_valid to any output; in_ready depends combinationally on out_ready only.

## Test plan
- Reset, N=3, DEFAULT_TABLE=8'h08: in_bits 000…111 streamed with out_ready=1 → out_bit=1 only at out_index=4, one result per cycle, latency 1.
- Serial load 8'h96 (bits 1,0,0,1,0,1,1,0), then sweep → out_bit sequence 1,0,0,1,0,1,1,0 for indices 0–7, then sweep_done pulse; cfg_ready low from the 8th bit until 1 cycle after commit.
- Backpressure: out_ready=0 for 5 cycles mid-sweep → out_valid, out_bit and out_index held stable; no index skipped or duplicated; in_ready=0 throughout.
- Load completes during a sweep of 8'h08 → sweep outputs stay 8'h08; the new table commits on the IDLE edge; a subsequent evaluation uses the new table.
- rst asserted at sweep index 3 → next cycle out_valid=0, busy=0, table=DEFAULT_TABLE; partial config discarded; cfg_ready=1.
- N_INPUTS=4, DEFAULT_TABLE=16'h8000 → only index 0 yields 1; sweep length 16 cycles.
